// File: rtl/bram_portb_arbiter.sv
// bram_portb_arbiter: shares BRAM port B between the LED-matrix frame reader
// (read-only) and the controller-state writer (read/write). Round-robin grants
// with a burst limit, one IDLE turnaround cycle on every ownership change, and
// a tagged read-return pipe that steers q_b back to whoever issued the read.
module bram_portb_arbiter #(
  parameter int AW        = 16,
  parameter int DW        = 16,
  parameter int MAX_BURST = 8,
  parameter int READ_LAT  = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m_req,
  input  logic [AW-1:0] m_addr,
  output logic          m_gnt,
  output logic          m_rvalid,
  output logic [DW-1:0] m_rdata,
  input  logic          c_req,
  input  logic          c_we,
  input  logic [AW-1:0] c_addr,
  input  logic [DW-1:0] c_wdata,
  output logic          c_gnt,
  output logic          c_rvalid,
  output logic [DW-1:0] c_rdata,
  output logic [AW-1:0] addr_b,
  output logic [DW-1:0] data_b,
  output logic          we_b,
  input  logic [DW-1:0] q_b
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_M = 2'd1,
    OWN_C = 2'd2
  } state_t;

  localparam int            CW         = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
  localparam logic [CW-1:0] BURST_LAST = CW'(MAX_BURST - 1);

  state_t        state_r, state_s;
  logic          last_c_r, last_c_s;     // 1 = controller held the port last
  logic [CW-1:0] cnt_r, cnt_s;           // beats taken in the current grant
  logic          m_beat_s, c_beat_s;
  logic          rd_push_s;
  logic [AW-1:0] addr_hold_r;
  logic [DW-1:0] data_hold_r;
  logic [READ_LAT-1:0] pipe_vld_r;       // read in flight at each stage
  logic [READ_LAT-1:0] pipe_c_r;         // 1 = read belongs to controller

  // A beat is a cycle where the current owner still asserts its request.
  always_comb begin
    m_beat_s  = (state_r == OWN_M) && m_req;
    c_beat_s  = (state_r == OWN_C) && c_req;
    rd_push_s = m_beat_s || (c_beat_s && !c_we);
  end

  // Next-state logic: arbitration from IDLE, release on drop or burst limit.
  always_comb begin
    state_s  = state_r;
    last_c_s = last_c_r;
    cnt_s    = cnt_r;
    case (state_r)
      IDLE: begin
        cnt_s = '0;
        if (m_req && c_req) begin
          state_s = last_c_r ? OWN_M : OWN_C;
        end else if (m_req) begin
          state_s = OWN_M;
        end else if (c_req) begin
          state_s = OWN_C;
        end else begin
          state_s = IDLE;
        end
      end
      OWN_M: begin
        if (!m_req) begin
          state_s = IDLE;
          cnt_s   = '0;
        end else if (cnt_r == BURST_LAST) begin
          cnt_s = '0;
          if (c_req) begin
            state_s  = IDLE;
            last_c_s = 1'b0;
          end else begin
            state_s = OWN_M;
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      OWN_C: begin
        if (!c_req) begin
          state_s = IDLE;
          cnt_s   = '0;
        end else if (cnt_r == BURST_LAST) begin
          cnt_s = '0;
          if (m_req) begin
            state_s  = IDLE;
            last_c_s = 1'b1;
          end else begin
            state_s = OWN_C;
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      default: begin
        state_s = IDLE;
        cnt_s   = '0;
      end
    endcase
  end

  // Arbiter state register; reset makes the matrix win the first tie.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= IDLE;
      last_c_r <= 1'b1;
      cnt_r    <= '0;
    end else begin
      state_r  <= state_s;
      last_c_r <= last_c_s;
      cnt_r    <= cnt_s;
    end
  end

  // Port B drive: owner's address on a beat, otherwise hold the last beat.
  always_comb begin
    addr_b = addr_hold_r;
    data_b = data_hold_r;
    we_b   = 1'b0;
    if (m_beat_s) begin
      addr_b = m_addr;
      data_b = c_wdata;
      we_b   = 1'b0;
    end else if (c_beat_s) begin
      addr_b = c_addr;
      data_b = c_wdata;
      we_b   = c_we;
    end else begin
      addr_b = addr_hold_r;
      data_b = data_hold_r;
      we_b   = 1'b0;
    end
  end

  // Remember the last beat's address/data so the bus is quiet between beats.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_hold_r <= '0;
      data_hold_r <= '0;
    end else if (m_beat_s || c_beat_s) begin
      addr_hold_r <= addr_b;
      data_hold_r <= data_b;
    end else begin
      addr_hold_r <= addr_hold_r;
      data_hold_r <= data_hold_r;
    end
  end

  // Read-return tag pipe, aligned with the BRAM read latency.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pipe_vld_r <= '0;
      pipe_c_r   <= '0;
    end else begin
      pipe_vld_r[0] <= rd_push_s;
      pipe_c_r[0]   <= c_beat_s;
      for (int i = 1; i < READ_LAT; i++) begin
        pipe_vld_r[i] <= pipe_vld_r[i-1];
        pipe_c_r[i]   <= pipe_c_r[i-1];
      end
    end
  end

  assign m_gnt    = (state_r == OWN_M);
  assign c_gnt    = (state_r == OWN_C);
  assign m_rvalid = pipe_vld_r[READ_LAT-1] && !pipe_c_r[READ_LAT-1];
  assign c_rvalid = pipe_vld_r[READ_LAT-1] &&  pipe_c_r[READ_LAT-1];
  assign m_rdata  = q_b;
  assign c_rdata  = q_b;

endmodule

// File: tb/tb_bram_portb_arbiter.sv
// Directed bench for bram_portb_arbiter with a one-cycle-latency BRAM model.
module tb_bram_portb_arbiter;

  logic        clk;
  logic        reset;
  logic        m_req;
  logic [15:0] m_addr;
  logic        m_gnt;
  logic        m_rvalid;
  logic [15:0] m_rdata;
  logic        c_req;
  logic        c_we;
  logic [15:0] c_addr;
  logic [15:0] c_wdata;
  logic        c_gnt;
  logic        c_rvalid;
  logic [15:0] c_rdata;
  logic [15:0] addr_b;
  logic [15:0] data_b;
  logic        we_b;
  logic [15:0] q_b;

  logic [15:0] mem [0:65535];

  int checks;
  int errors;

  bram_portb_arbiter #(.AW(16), .DW(16), .MAX_BURST(8), .READ_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .m_req(m_req), .m_addr(m_addr), .m_gnt(m_gnt), .m_rvalid(m_rvalid), .m_rdata(m_rdata),
    .c_req(c_req), .c_we(c_we), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_gnt(c_gnt), .c_rvalid(c_rvalid), .c_rdata(c_rdata),
    .addr_b(addr_b), .data_b(data_b), .we_b(we_b), .q_b(q_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // BRAM model: preload mem[a] = 0xA000 + a while in reset, read-first port.
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 256; i++) mem[16'(i)] <= 16'hA000 + 16'(i);
      q_b <= 16'h0000;
    end else begin
      if (we_b) mem[addr_b] <= data_b;
      q_b <= mem[addr_b];
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs;
    m_req = 1'b0; m_addr = 16'h0000;
    c_req = 1'b0; c_we = 1'b0; c_addr = 16'h0000; c_wdata = 16'h0000;
  endtask

  task automatic do_reset;
    idle_inputs();
    reset = 1'b0;
    tick(); tick();
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset;
    idle_inputs();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if ({m_gnt, c_gnt, we_b, m_rvalid, c_rvalid} !== 5'b00000) begin
      errors++; $display("FAIL reset_ctrl got %b want 00000", {m_gnt, c_gnt, we_b, m_rvalid, c_rvalid});
    end
    checks++;
    if ({addr_b, data_b} !== 32'h0000_0000) begin
      errors++; $display("FAIL reset_bus got %h want 00000000", {addr_b, data_b});
    end
    tick(); tick();
    #2;
    reset = 1'b1;
  endtask

  task automatic test_single_read;
    tick(); m_req = 1'b1; m_addr = 16'h0010; #2;
    checks++;
    if (m_gnt !== 1'b0) begin errors++; $display("FAIL rd_pregnt got %b want 0", m_gnt); end
    tick(); #2;
    checks++;
    if ({m_gnt, c_gnt, we_b} !== 3'b100) begin
      errors++; $display("FAIL rd_gnt got %b want 100", {m_gnt, c_gnt, we_b});
    end
    checks++;
    if (addr_b !== 16'h0010) begin errors++; $display("FAIL rd_addr got %h want 0010", addr_b); end
    tick(); m_req = 1'b0; #2;
    checks++;
    if ({m_rvalid, c_rvalid} !== 2'b10) begin
      errors++; $display("FAIL rd_rvalid got %b want 10", {m_rvalid, c_rvalid});
    end
    checks++;
    if (m_rdata !== 16'hA010) begin errors++; $display("FAIL rd_data got %h want a010", m_rdata); end
    checks++;
    if (addr_b !== 16'h0010) begin errors++; $display("FAIL rd_hold got %h want 0010", addr_b); end
    tick(); #2;
    checks++;
    if ({m_gnt, m_rvalid} !== 2'b00) begin
      errors++; $display("FAIL rd_release got %b want 00", {m_gnt, m_rvalid});
    end
  endtask

  task automatic test_ctrl_write_read;
    tick(); c_req = 1'b1; c_we = 1'b1; c_addr = 16'h0020; c_wdata = 16'hBEEF; #2;
    tick(); #2;
    checks++;
    if ({c_gnt, m_gnt, we_b} !== 3'b101) begin
      errors++; $display("FAIL wr_gnt got %b want 101", {c_gnt, m_gnt, we_b});
    end
    checks++;
    if ({addr_b, data_b} !== 32'h0020_BEEF) begin
      errors++; $display("FAIL wr_bus got %h want 0020beef", {addr_b, data_b});
    end
    tick(); c_we = 1'b0; #2;
    checks++;
    if (we_b !== 1'b0) begin errors++; $display("FAIL wr_one_cycle got %b want 0", we_b); end
    tick(); c_req = 1'b0; #2;
    checks++;
    if ({c_rvalid, m_rvalid, we_b} !== 3'b100) begin
      errors++; $display("FAIL crd_rvalid got %b want 100", {c_rvalid, m_rvalid, we_b});
    end
    checks++;
    if (c_rdata !== 16'hBEEF) begin errors++; $display("FAIL crd_data got %h want beef", c_rdata); end
    tick(); #2;
    checks++;
    if ({c_gnt, c_rvalid} !== 2'b00) begin
      errors++; $display("FAIL crd_release got %b want 00", {c_gnt, c_rvalid});
    end
    idle_inputs();
  endtask

  task automatic test_round_robin;
    logic exp_m, exp_c, prev_m, prev_c;
    int p;
    do_reset();
    prev_m = 1'b0; prev_c = 1'b0;
    for (int i = 0; i < 28; i++) begin
      tick();
      m_req = 1'b1; c_req = 1'b1; c_we = 1'b0; m_addr = 16'h0060; c_addr = 16'h0061;
      #2;
      p = (i == 0) ? 17 : (i - 1) % 18;
      exp_m = (p <= 7);
      exp_c = (p >= 9) && (p <= 16);
      checks++;
      if ({m_gnt, c_gnt} !== {exp_m, exp_c}) begin
        errors++; $display("FAIL rr_gnt cycle %0d got %b want %b", i, {m_gnt, c_gnt}, {exp_m, exp_c});
      end
      checks++;
      if ({m_rvalid, c_rvalid} !== {prev_m, prev_c}) begin
        errors++; $display("FAIL rr_rvalid cycle %0d got %b want %b", i, {m_rvalid, c_rvalid}, {prev_m, prev_c});
      end
      prev_m = exp_m; prev_c = exp_c;
    end
    idle_inputs();
  endtask

  task automatic test_no_forced_release;
    int beats, rets;
    do_reset();
    beats = 0; rets = 0;
    for (int i = 0; i < 22; i++) begin
      tick();
      m_req = (i < 21) ? 1'b1 : 1'b0;
      m_addr = 16'h0070;
      #2;
      if (i >= 1 && i <= 20) begin
        checks++;
        if ({m_gnt, c_gnt} !== 2'b10) begin
          errors++; $display("FAIL solo_gnt cycle %0d got %b want 10", i, {m_gnt, c_gnt});
        end
      end
      if (m_gnt && m_req) beats++;
      if (m_rvalid) rets++;
    end
    checks++;
    if (beats !== 20) begin errors++; $display("FAIL solo_beats got %0d want 20", beats); end
    checks++;
    if (rets !== 20) begin errors++; $display("FAIL solo_returns got %0d want 20", rets); end
    idle_inputs();
  endtask

  task automatic test_handover_return;
    do_reset();
    for (int i = 0; i < 11; i++) begin
      tick();
      m_req = 1'b1; c_req = 1'b1; c_we = 1'b0;
      m_addr = 16'h0040 + 16'(i); c_addr = 16'h0030;
      #2;
      if (i == 9) begin
        checks++;
        if ({m_gnt, c_gnt, m_rvalid, c_rvalid} !== 4'b0010) begin
          errors++; $display("FAIL ho_idle got %b want 0010", {m_gnt, c_gnt, m_rvalid, c_rvalid});
        end
        checks++;
        if (m_rdata !== 16'hA048) begin errors++; $display("FAIL ho_data got %h want a048", m_rdata); end
      end
      if (i == 10) begin
        checks++;
        if ({m_gnt, c_gnt, m_rvalid} !== 3'b010) begin
          errors++; $display("FAIL ho_next got %b want 010", {m_gnt, c_gnt, m_rvalid});
        end
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_mid_burst;
    do_reset();
    for (int i = 0; i < 13; i++) begin
      tick();
      m_req = 1'b1; c_req = 1'b1; m_addr = 16'h0080;
      c_addr = 16'h0050; c_wdata = 16'h1234;
      c_we = ((i % 2) == 0) ? 1'b1 : 1'b0;
      #2;
    end
    checks++;
    if ({c_gnt, we_b, c_rvalid} !== 3'b111) begin
      errors++; $display("FAIL mid_pre got %b want 111", {c_gnt, we_b, c_rvalid});
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({m_gnt, c_gnt, we_b, m_rvalid, c_rvalid} !== 5'b00000) begin
      errors++; $display("FAIL mid_drop got %b want 00000", {m_gnt, c_gnt, we_b, m_rvalid, c_rvalid});
    end
    tick(); #2;
    checks++;
    if ({m_gnt, c_gnt, m_rvalid, c_rvalid} !== 4'b0000) begin
      errors++; $display("FAIL mid_held got %b want 0000", {m_gnt, c_gnt, m_rvalid, c_rvalid});
    end
    reset = 1'b1;
    tick(); #2;
    checks++;
    if ({m_gnt, c_gnt} !== 2'b10) begin
      errors++; $display("FAIL mid_tie got %b want 10", {m_gnt, c_gnt});
    end
    idle_inputs();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    idle_inputs();
    test_reset();
    test_single_read();
    test_ctrl_write_read();
    test_round_robin();
    test_no_forced_release();
    test_handover_return();
    test_reset_mid_burst();
    tick(); tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
